axi_rw_mem_device: RTL
======================

Name: axi_rw_mem_device

Overview:
- Device-side responder for the `axi_bus_rw` read/write bus. It accepts one read or one write address handshake at a time and holds it for a programmable latency.
- It then returns sign- or zero-extended read data, or applies a byte-strobed write and pulses a write response.
- It is the main-memory model behind the cache and controller blocks, and the target used by their benches.

Parameters:
- WIDTH, 32, data width in bits; must be 32.
- DEPTH_WORDS, 1024, number of WIDTH-bit words; power of 2.
- READ_LATENCY, 4, cycles from read address handshake to `read_data_valid`; allowed range 1..15.
- WRITE_LATENCY, 4, cycles from write address handshake to `write_resp_valid`; allowed range 1..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- read_addr  in  `ADDR_WIDTH  byte address of the read.
- read_addr_valid  in  1  controller requests a read.
- read_addr_ready  out  1  device can accept a read.
- read_data  out  WIDTH  extended read result.
- read_data_valid  out  1  one-cycle pulse; `read_data` is valid in that cycle.
- write_addr  in  `ADDR_WIDTH  byte address of the write.
- write_addr_valid  in  1  controller requests a write.
- write_addr_ready  out  1  device can accept a write.
- write_data  in  WIDTH  write data, already lane-aligned by the controller.
- write_resp_valid  out  1  one-cycle pulse; the write has been committed.
- strobe  in  `WORD_SIZE  byte enables for the write.
- size  in  2  read size: 0 byte, 1 half, 2 word, 3 treated as word.
- lu  in  1  read is unsigned (zero-extend).

Behaviour:
- FSM states are IDLE, RD_WAIT and WR_WAIT. A 4-bit latency counter `cnt` runs in the wait states.
- Reset values: state=IDLE, cnt=0, `read_data`=0, `read_data_valid`=0, `write_resp_valid`=0. Memory contents are not cleared by reset.
- Ready signals are combinational:
  - `write_addr_ready` = (state==IDLE).
  - `read_addr_ready` = (state==IDLE) && !`write_addr_valid`.
  - A simultaneous read and write request in IDLE therefore accepts the write. The read stays pending, and the controller must hold `read_addr_valid`.
- Write acceptance (IDLE && `write_addr_valid`):
  - Latch `write_addr`, `write_data` and `strobe`.
  - Set cnt=WRITE_LATENCY-1 and go to WR_WAIT.
- Read acceptance (IDLE && `read_addr_valid` && `read_addr_ready`):
  - Latch `read_addr`, `size` and `lu`.
  - Set cnt=READ_LATENCY-1 and go to RD_WAIT.
- In a wait state with cnt!=0: decrement cnt each cycle.
- RD_WAIT with cnt==0:
  - Register `read_data` and assert `read_data_valid` for one cycle, then return to IDLE.
  - Latency: the handshake at edge N gives `read_data_valid` high in the cycle after edge N+READ_LATENCY.
- WR_WAIT with cnt==0:
  - Write mem[idx], byte lane i only where strobe[i]=1.
  - Pulse `write_resp_valid` for one cycle, then return to IDLE.
  - The memory update and the response are visible at the same edge.
- A new handshake is accepted no earlier than the cycle in which the response pulse is high, because state is already IDLE then. Throughput is one transaction per latency+1 cycles.
- Index: idx = addr[$clog2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo the memory size.
- Read extraction from word w = mem[idx]:
  - size 0: byte w[8*a+7:8*a], where a = addr[1:0].
  - size 1: halfword w[16*h+15:16*h], where h = addr[1]; addr[0] is ignored.
  - size 2 or 3: the whole word; addr[1:0] is ignored.
  - The result is sign-extended when lu=0 and zero-extended when lu=1.
- `read_data` holds its last value outside the valid pulse.
- Reset mid-transaction: the transaction is abandoned. No memory write occurs and no response pulse is issued. RST has priority over every other event.
- Inputs are sampled only at the handshake. Changes to them during a wait state have no effect.

Test Plan:
- Reset then idle: after RST, `read_addr_ready`=1, `write_addr_ready`=1, `read_data_valid`=0, `write_resp_valid`=0, `read_data`=0.
- Write then read, latency check:
  - Write addr 0x10, data 0xDEADBEEF, strobe 4'b1111. `write_resp_valid` pulses exactly 4 cycles after the handshake.
  - Read 0x10 with size 2. `read_data`=0xDEADBEEF with `read_data_valid` high for exactly 1 cycle, 4 cycles after the handshake.
- Strobe and extension, starting from word 0xDEADBEEF at 0x10:
  - Write data 0x00AA0000 with strobe 4'b0100 to 0x10; the word becomes 0xDEAABEEF.
  - Read size 0, addr 0x12, lu=0 → 0xFFFFFFAA.
  - Read size 0, addr 0x12, lu=1 → 0x000000AA.
  - Read size 1, addr 0x10, lu=0 → 0xFFFFBEEF.
- Simultaneous requests: in IDLE, raise `read_addr_valid` and `write_addr_valid` together. The write is accepted (`read_addr_ready`=0). The read is accepted in the cycle the write response pulses, and returns the newly written data.
- Wrap and latency edge: with READ_LATENCY=1, write 0x11223344 to address 4 then read address 4+4*DEPTH_WORDS. `read_data_valid` appears 1 cycle after the handshake with data 0x11223344.
- Reset mid-write: assert RST 2 cycles into a write to 0x20. No `write_resp_valid` pulse follows. A later read of 0x20 returns the old contents.

Source files
------------

// File: rtl/axi_rw_mem_device_if.sv
// Read/write request bus between a memory controller (master) and the memory device (slave).
interface axi_rw_mem_device_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WIDTH      = 32
);
  localparam int WORD_SIZE = WIDTH / 8;

  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  read_addr_valid;
  logic                  read_addr_ready;
  logic [WIDTH-1:0]      read_data;
  logic                  read_data_valid;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  write_addr_valid;
  logic                  write_addr_ready;
  logic [WIDTH-1:0]      write_data;
  logic                  write_resp_valid;
  logic [WORD_SIZE-1:0]  strobe;
  logic [1:0]            size;
  logic                  lu;

  modport master (
    output read_addr, read_addr_valid, write_addr, write_addr_valid,
    output write_data, strobe, size, lu,
    input  read_addr_ready, read_data, read_data_valid,
    input  write_addr_ready, write_resp_valid
  );

  modport slave (
    input  read_addr, read_addr_valid, write_addr, write_addr_valid,
    input  write_data, strobe, size, lu,
    output read_addr_ready, read_data, read_data_valid,
    output write_addr_ready, write_resp_valid
  );
endinterface

// File: rtl/axi_rw_mem_device.sv
// Main-memory responder: one read or write in flight, fixed latency, byte-strobed writes and
// sign/zero-extended byte/half/word reads.
module axi_rw_mem_device #(
  parameter int WIDTH         = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4,
  parameter int ADDR_WIDTH    = 32
) (
  input logic               CLK,
  input logic               RST,
  axi_rw_mem_device_if.slave bus
);
  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int WORD_SIZE = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic [WIDTH-1:0]     mem [DEPTH_WORDS];

  logic [IDX_W-1:0]     rd_idx_q;
  logic [1:0]           rd_off_q;
  logic [1:0]           rd_size_q;
  logic                 rd_lu_q;
  logic [IDX_W-1:0]     wr_idx_q;
  logic [WIDTH-1:0]     wr_data_q;
  logic [WORD_SIZE-1:0] wr_strobe_q;

  logic [WIDTH-1:0]     read_data_q;
  logic                 read_data_valid_q;
  logic                 write_resp_valid_q;

  logic [WIDTH-1:0]     rd_word;
  logic [WIDTH-1:0]     rd_ext;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;

  // Write wins a tie so the controller's read simply stays pending.
  assign bus.write_addr_ready = (state == IDLE);
  assign bus.read_addr_ready  = (state == IDLE) && !bus.write_addr_valid;
  assign bus.read_data        = read_data_q;
  assign bus.read_data_valid  = read_data_valid_q;
  assign bus.write_resp_valid = write_resp_valid_q;

  always_comb begin
    rd_word = mem[rd_idx_q];
    rd_byte = rd_word[{rd_off_q, 3'b000} +: 8];
    rd_half = rd_word[{rd_off_q[1], 4'b0000} +: 16];
    case (rd_size_q)
      2'd0:    rd_ext = {{(WIDTH-8){~rd_lu_q & rd_byte[7]}}, rd_byte};
      2'd1:    rd_ext = {{(WIDTH-16){~rd_lu_q & rd_half[15]}}, rd_half};
      default: rd_ext = rd_word;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state              <= IDLE;
      cnt                <= 4'd0;
      read_data_q        <= '0;
      read_data_valid_q  <= 1'b0;
      write_resp_valid_q <= 1'b0;
    end else begin
      read_data_valid_q  <= 1'b0;
      write_resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.write_addr_valid) begin
            wr_idx_q    <= bus.write_addr[IDX_W+1:2];
            wr_data_q   <= bus.write_data;
            wr_strobe_q <= bus.strobe;
            cnt         <= 4'(WRITE_LATENCY - 1);
            state       <= WR_WAIT;
          end else if (bus.read_addr_valid) begin
            rd_idx_q  <= bus.read_addr[IDX_W+1:2];
            rd_off_q  <= bus.read_addr[1:0];
            rd_size_q <= bus.size;
            rd_lu_q   <= bus.lu;
            cnt       <= 4'(READ_LATENCY - 1);
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            read_data_q       <= rd_ext;
            read_data_valid_q <= 1'b1;
            state             <= IDLE;
          end
        end
        WR_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            write_resp_valid_q <= 1'b1;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; a write abandoned by RST never lands.
  always_ff @(posedge CLK) begin
    if (!RST && state == WR_WAIT && cnt == 4'd0) begin
      for (int i = 0; i < WORD_SIZE; i++) begin
        if (wr_strobe_q[i]) begin
          mem[wr_idx_q][8*i +: 8] <= wr_data_q[8*i +: 8];
        end
      end
    end
  end
endmodule
